// File: rtl/bsg_sort_seq_pkg.sv
// Shared types and helpers for the sequential compare-and-swap sorter.
package bsg_sort_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Even phases cover (0,1),(2,3)...; odd phases skip both end elements.
  function automatic int pairs_per_phase(input logic odd, input int els);
    return odd ? (els/2 - 1) : (els/2);
  endfunction

endpackage

// File: rtl/bsg_compare_and_swap.sv
// Orders the two halves of data_i so the upper half holds the larger value.
module bsg_compare_and_swap #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] data_i,
  input  logic               swap_on_equal_i,
  output logic [width_p-1:0] data_o,
  output logic               swapped_o
);

  localparam int half_lp = width_p/2;

  logic [half_lp-1:0] lo, hi;

  assign lo        = data_i[half_lp-1:0];
  assign hi        = data_i[width_p-1:half_lp];
  assign swapped_o = (lo > hi) | (swap_on_equal_i & (lo == hi));
  assign data_o    = swapped_o ? {lo, hi} : data_i;

endmodule

// File: rtl/bsg_sort_seq_cas.sv
// Burst sorter: load els_p words, odd-even transposition sort with one shared
// compare-and-swap per cycle, then stream the words out ascending.
module bsg_sort_seq_cas
  import bsg_sort_seq_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic [width_p-1:0]              data_i,
  output logic                            ready_o,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  input  logic                            yumi_i,
  output logic                            busy_o,
  output logic [$clog2(els_p*els_p):0]    swaps_o
);

  localparam int iw_lp  = $clog2(els_p);
  localparam int pw_lp  = (els_p > 2) ? $clog2(els_p/2) : 1;
  localparam int phw_lp = $clog2(els_p) + 1;
  localparam int sw_lp  = $clog2(els_p*els_p) + 1;

  state_e               state_r, state_n;
  logic [width_p-1:0]   buf_r [els_p];
  logic [iw_lp-1:0]     idx_r;
  logic [pw_lp-1:0]     pair_r;
  logic [phw_lp-1:0]    phase_r;
  logic                 dirty_r, prev_clean_r;
  logic [sw_lp-1:0]     swaps_r;

  logic [iw_lp-1:0]     j_lo, j_hi;
  logic [2*width_p-1:0] cas_out;
  logic                 swapped, idx_last, pair_last, cur_clean, last_phase, sort_done;

  assign idx_last = (idx_r == iw_lp'(els_p-1));
  assign j_lo     = iw_lp'({pair_r, 1'b0}) | iw_lp'(phase_r[0]);
  assign j_hi     = j_lo + iw_lp'(1);

  bsg_compare_and_swap #(.width_p(2*width_p)) cas (
    .data_i          ({buf_r[j_hi], buf_r[j_lo]}),
    .swap_on_equal_i (1'b0),
    .data_o          (cas_out),
    .swapped_o       (swapped)
  );

  // With els_p == 2 the odd phase is empty, so the even phase also closes it.
  assign pair_last  = (int'(pair_r) == pairs_per_phase(phase_r[0], els_p) - 1);
  assign cur_clean  = ~(dirty_r | swapped);
  assign last_phase = (phase_r == phw_lp'(els_p-1)) ||
                      ((pairs_per_phase(1'b1, els_p) == 0) && (phase_r == phw_lp'(els_p-2)));
  assign sort_done  = pair_last &&
                      (last_phase || ((phase_r != '0) && cur_clean && prev_clean_r));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= LOAD;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    busy_o  = 1'b0;
    data_o  = '0;
    unique case (state_r)
      LOAD: begin
        ready_o = 1'b1;
        if (v_i && idx_last) state_n = SORT;
      end
      SORT: begin
        busy_o = 1'b1;
        if (sort_done) state_n = DRAIN;
      end
      DRAIN: begin
        v_o    = 1'b1;
        data_o = buf_r[idx_r];
        if (yumi_i && idx_last) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) buf_r[i] <= '0;
      idx_r        <= '0;
      pair_r       <= '0;
      phase_r      <= '0;
      dirty_r      <= 1'b0;
      prev_clean_r <= 1'b0;
      swaps_r      <= '0;
    end else begin
      unique case (state_r)
        LOAD: if (v_i) begin
          buf_r[idx_r] <= data_i;
          if (idx_last) begin
            idx_r        <= '0;
            pair_r       <= '0;
            phase_r      <= '0;
            dirty_r      <= 1'b0;
            prev_clean_r <= 1'b0;
            swaps_r      <= '0;
          end else begin
            idx_r <= idx_r + iw_lp'(1);
          end
        end
        SORT: begin
          buf_r[j_lo] <= cas_out[width_p-1:0];
          buf_r[j_hi] <= cas_out[2*width_p-1:width_p];
          swaps_r     <= swaps_r + sw_lp'(swapped);
          if (pair_last) begin
            pair_r       <= '0;
            phase_r      <= phase_r + phw_lp'(1);
            prev_clean_r <= cur_clean;
            dirty_r      <= 1'b0;
          end else begin
            pair_r  <= pair_r + pw_lp'(1);
            dirty_r <= dirty_r | swapped;
          end
        end
        DRAIN: if (yumi_i) idx_r <= idx_last ? '0 : idx_r + iw_lp'(1);
        default: ;
      endcase
    end
  end

  assign swaps_o = swaps_r;

endmodule

// File: tb/tb_bsg_sort_seq_cas.sv
// Scoreboard bench for bsg_sort_seq_cas: els_p=8 main instance plus an els_p=2 instance.
module tb_bsg_sort_seq_cas;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        v_i, ready_o, v_o, yumi_i, busy_o;
  logic [15:0] data_i, data_o;
  logic [6:0]  swaps_o;

  logic        v2_i, ready2_o, v2_o, yumi2_i, busy2_o;
  logic [15:0] data2_i, data2_o;
  logic [2:0]  swaps2_o;

  bsg_sort_seq_cas #(.width_p(16), .els_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .busy_o(busy_o), .swaps_o(swaps_o)
  );

  bsg_sort_seq_cas #(.width_p(16), .els_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .v_i(v2_i), .data_i(data2_i), .ready_o(ready2_o),
    .v_o(v2_o), .data_o(data2_o), .yumi_i(yumi2_i), .busy_o(busy2_o), .swaps_o(swaps2_o)
  );

  always @(posedge clk) if (!rst) begin
    assert (!(yumi_i && !v_o))   else $error("yumi_i without v_o");
    assert (!(yumi2_i && !v2_o)) else $error("yumi2_i without v2_o");
  end

  typedef logic [15:0] burst_t [8];

  int          total = 0, bad = 0;
  int          badhs = 0;
  logic [15:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one burst (optionally gapped), pushes the reference-sorted words
  // and returns the strict inversion count, which equals the swap count.
  task automatic send_burst(input burst_t b, input int gap_pct, output int inv);
    burst_t      s;
    logic [15:0] t;
    logic        acc;
    int          i = 0, guard = 0;
    inv = 0;
    for (int a = 0; a < 8; a++)
      for (int c = a + 1; c < 8; c++)
        if (b[a] > b[c]) inv++;
    s = b;
    for (int a = 0; a < 7; a++)
      for (int c = 0; c < 7 - a; c++)
        if (s[c] > s[c+1]) begin t = s[c]; s[c] = s[c+1]; s[c+1] = t; end
    for (int a = 0; a < 8; a++) sb.push_back(s[a]);
    while (i < 8 && guard < 1000) begin
      @(negedge clk);
      guard++;
      yumi_i = 1'b0;
      if (!ready_o || v_o || busy_o) badhs++;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) v_i = 1'b0;
      else begin v_i = 1'b1; data_i = b[i]; end
      acc = v_i && ready_o;
      @(posedge clk);
      if (acc) i++;
    end
    if (i < 8) chk("load_timeout", 0, 1);
    @(negedge clk);
    v_i = 1'b0;
  endtask

  // Counts SORT cycles; v_i is toggled to show it is ignored outside LOAD.
  task automatic measure_sort(output int cyc);
    cyc = 0;
    while (busy_o && cyc < 200) begin
      cyc++;
      if (ready_o || v_o) badhs++;
      v_i    = 1'($urandom_range(0, 1));
      data_i = 16'($urandom);
      @(negedge clk);
    end
    v_i = 1'b0;
    if (cyc >= 200) chk("sort_timeout", 0, 1);
    chk("v_after_sort", {busy_o, v_o}, 2'b01);
  endtask

  task automatic drain(input int yumi_pct);
    int          n = 0, guard = 0;
    logic [15:0] exp;
    while (n < 8 && guard < 1000) begin
      guard++;
      v_i = 1'b0;
      if (ready_o || busy_o) badhs++;
      if (v_o && (yumi_pct >= 100 || $urandom_range(0, 99) < yumi_pct)) begin
        yumi_i = 1'b1;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin exp = sb.pop_front(); chk("data", data_o, exp); end
        n++;
      end else yumi_i = 1'b0;
      @(negedge clk);
    end
    yumi_i = 1'b0;
    if (n < 8) chk("drain_timeout", 0, 1);
    chk("reload", {ready_o, v_o, busy_o}, 3'b100);
    chk("handshake_outside_load", badhs, 0);
    badhs = 0;
  endtask

  initial begin
    burst_t b;
    int     inv, cyc;
    rst = 1'b1; v_i = 0; yumi_i = 0; data_i = 0;
    v2_i = 0; yumi2_i = 0; data2_i = 0;
    #12;
    chk("rst_outs", {ready_o, v_o, busy_o, data_o}, {3'b100, 16'h0});
    chk("rst_swaps", swaps_o, 0);
    chk("rst2_outs", {ready2_o, v2_o, busy2_o, swaps2_o}, {3'b100, 3'd0});
    @(negedge clk); rst = 1'b0;

    // reverse: worst case
    b = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    send_burst(b, 0, inv);
    measure_sort(cyc);
    chk("rev_cycles", cyc, 28);
    chk("rev_swaps", swaps_o, 28);
    drain(100);
    chk("swaps_hold", swaps_o, 28);

    // already sorted: early exit
    b = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    send_burst(b, 0, inv);
    measure_sort(cyc);
    chk("sorted_cycles", cyc, 7);
    chk("sorted_swaps", swaps_o, 0);
    drain(100);

    // duplicates and extremes
    b = '{16'hFFFF, 16'd3, 16'd3, 16'd0, 16'hFFFF, 16'd1, 16'd0, 16'd3};
    send_burst(b, 0, inv);
    measure_sort(cyc);
    chk("dup_swaps", swaps_o, inv);
    drain(100);

    // random bursts with backpressure on both sides
    for (int r = 0; r < 100; r++) begin
      for (int k = 0; k < 8; k++)
        b[k] = (r % 2) ? 16'($urandom_range(0, 5)) : 16'($urandom);
      send_burst(b, 50, inv);
      measure_sort(cyc);
      chk("rnd_cyc_range", (cyc >= 7 && cyc <= 28), 1);
      chk("rnd_swaps", swaps_o, inv);
      drain(50);
    end

    // async reset mid-SORT discards the burst
    b = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    send_burst(b, 0, inv);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outs", {ready_o, v_o, busy_o, data_o}, {3'b100, 16'h0});
    chk("midrst_swaps", swaps_o, 0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    b = '{16'd3, 16'd9, 16'd1, 16'd1, 16'd8, 16'd0, 16'd5, 16'd2};
    send_burst(b, 0, inv);
    measure_sort(cyc);
    chk("post_rst_swaps", swaps_o, inv);
    drain(100);

    // els_p = 2 instance: 9,4 -> 4,9
    @(negedge clk); v2_i = 1'b1; data2_i = 16'd9;
    @(negedge clk); data2_i = 16'd4;
    @(negedge clk); v2_i = 1'b0;
    cyc = 0;
    while (busy2_o && cyc < 50) begin cyc++; @(negedge clk); end
    chk("e2_cycles", cyc, 1);
    chk("e2_swaps", swaps2_o, 1);
    chk("e2_v0", v2_o, 1);
    chk("e2_d0", data2_o, 16'd4);
    yumi2_i = 1'b1;
    @(negedge clk);
    chk("e2_d1", data2_o, 16'd9);
    @(negedge clk);
    yumi2_i = 1'b0;
    chk("e2_reload", {ready2_o, v2_o}, 2'b10);

    chk("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
